// File: rtl/coord_stack.sv
// coord_stack: LIFO of {x,y} coordinate pairs with replace-top and fail pulse.
// Define COORD_STACK_PEEK_EN to expose combinational top_x/top_y.
module coord_stack #(
  parameter int COORD_W = 4,
  parameter int DEPTH   = 16,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               out_vld,
  output logic               fail,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
`ifdef COORD_STACK_PEEK_EN
  ,
  output logic [COORD_W-1:0] top_x,
  output logic [COORD_W-1:0] top_y
`endif
);

  logic [2*COORD_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]        r_sp;
  logic [COORD_W-1:0]   r_x_out;
  logic [COORD_W-1:0]   r_y_out;
  logic                 r_vld;
  logic                 r_fail;

  logic                 w_full;
  logic                 w_empty;
  logic [PW-1:0]        w_top;
  logic [PW-1:0]        w_sp_idx;
  logic [PW-1:0]        w_widx;
  logic                 w_we;
  logic [2*COORD_W-1:0] w_top_ent;

  assign w_full    = (r_sp == CW'(DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_top     = PW'(r_sp - CW'(1));
  assign w_sp_idx  = PW'(r_sp);
  assign w_top_ent = r_mem[w_top];

  // Replace writes over the old top; every other accepted write lands at sp.
  assign w_we   = push & (pop | ~w_full);
  assign w_widx = (pop & ~w_empty) ? w_top : w_sp_idx;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= {x_in, y_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_vld   <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_fail <= 1'b0;
      unique case ({push, pop})
        2'b10: begin
          if (!w_full) r_sp <= r_sp + CW'(1);
          else         r_fail <= 1'b1;
        end
        2'b01: begin
          if (!w_empty) begin
            {r_x_out, r_y_out} <= w_top_ent;
            r_vld <= 1'b1;
            r_sp  <= r_sp - CW'(1);
          end else begin
            r_fail <= 1'b1;
          end
        end
        2'b11: begin
          if (!w_empty) begin
            {r_x_out, r_y_out} <= w_top_ent;
            r_vld <= 1'b1;
          end else begin
            r_sp   <= CW'(1);
            r_fail <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_out   = r_x_out;
  assign y_out   = r_y_out;
  assign out_vld = r_vld;
  assign fail    = r_fail;
  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_sp;

`ifdef COORD_STACK_PEEK_EN
  assign top_x = w_empty ? '0 : w_top_ent[2*COORD_W-1:COORD_W];
  assign top_y = w_empty ? '0 : w_top_ent[COORD_W-1:0];
`endif

endmodule
